// File: rtl/instr_feeder.sv
// instr_feeder: buffered program sequencer driving the 9-bit processor's DIN/Run.
// Words are loaded while idle and issued one instruction at a time on Start.
module instr_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [8:0]    LoadData,
    input  logic          LoadWe,
    input  logic          Start,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic          Busy,
    output logic          Halted,
    output logic          Fault,
    output logic          LoadOvf,
    output logic [AW-1:0] PC,
    output logic [CW-1:0] WordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_OPERAND,
        S_WAIT,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [2:0]    OP_MVI = 3'b001;
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [7:0]    WD_MAX = 8'(TIMEOUT);

    state_t        state_q;
    logic [8:0]    buf_q [DEPTH];
    logic [8:0]    din_q;
    logic          run_q;
    logic          busy_q;
    logic          halted_q;
    logic          fault_q;
    logic          ovf_q;
    logic [AW-1:0] pc_q;
    logic [CW-1:0] wc_q;
    logic [7:0]    wd_q;
    logic          mvi_q;
    logic          trunc_q;

    logic          load_ok;
    logic [CW-1:0] pc_d;
    logic [8:0]    nx_word;
    logic          nx_mvi;
    logic          nx_trunc;
    logic [8:0]    w0;
    logic          w0_mvi;
    logic          w0_trunc;
    logic [8:0]    opnd_word;
    logic [7:0]    wd_d;

    assign load_ok = LoadWe && !busy_q && (wc_q != FULL);

    // Next-instruction lookahead so DIN/Run can be registered on entry to ISSUE.
    assign pc_d     = CW'(pc_q) + (mvi_q ? CW'(2) : CW'(1));
    assign nx_word  = buf_q[pc_d[AW-1:0]];
    assign nx_mvi   = (nx_word[8:6] == OP_MVI);
    assign nx_trunc = nx_mvi && ({1'b0, pc_d} + 1'b1 >= {1'b0, wc_q});

    assign w0       = buf_q[0];
    assign w0_mvi   = (w0[8:6] == OP_MVI);
    assign w0_trunc = w0_mvi && (wc_q <= CW'(1));

    assign opnd_word = buf_q[pc_q + AW'(1)];
    assign wd_d      = wd_q + 8'd1;

    always_ff @(posedge Clock) begin
        if (!Reset && load_ok) begin
            buf_q[wc_q[AW-1:0]] <= LoadData;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            din_q    <= 9'h000;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            ovf_q    <= 1'b0;
            pc_q     <= '0;
            wc_q     <= '0;
            wd_q     <= 8'd0;
            mvi_q    <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            din_q <= 9'h000;
            run_q <= 1'b0;

            if (LoadWe && !busy_q) begin
                if (wc_q == FULL) begin
                    ovf_q <= 1'b1;
                end else begin
                    wc_q <= wc_q + CW'(1);
                end
            end

            unique case (state_q)
                S_IDLE, S_HALT, S_FAULT: begin
                    if (Start) begin
                        halted_q <= 1'b0;
                        fault_q  <= 1'b0;
                        pc_q     <= '0;
                        if (wc_q == '0) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            busy_q  <= 1'b1;
                            din_q   <= w0;
                            run_q   <= !w0_trunc;
                            mvi_q   <= w0_mvi;
                            trunc_q <= w0_trunc;
                        end
                    end
                end
                S_ISSUE: begin
                    wd_q <= 8'd0;
                    if (trunc_q) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_OPERAND;
                        din_q   <= mvi_q ? opnd_word : 9'h000;
                    end
                end
                S_OPERAND, S_WAIT: begin
                    if (Done) begin
                        pc_q <= pc_d[AW-1:0];
                        if (pc_d >= wc_q) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= S_ISSUE;
                            din_q   <= nx_word;
                            run_q   <= !nx_trunc;
                            mvi_q   <= nx_mvi;
                            trunc_q <= nx_trunc;
                        end
                    end else if (wd_d >= WD_MAX) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        wd_q    <= wd_d;
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DIN       = din_q;
    assign Run       = run_q;
    assign Busy      = busy_q;
    assign Halted    = halted_q;
    assign Fault     = fault_q;
    assign LoadOvf   = ovf_q;
    assign PC        = pc_q;
    assign WordCount = wc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: vector table plus directed multi-cycle sequences
// for the instruction feeder with DEPTH=16, TIMEOUT=15.
module tb_instr_feeder;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [8:0] LoadData = 9'h000;
    logic       LoadWe = 1'b0;
    logic       Start = 1'b0;
    logic       Done = 1'b0;
    logic [8:0] DIN;
    logic       Run;
    logic       Busy;
    logic       Halted;
    logic       Fault;
    logic       LoadOvf;
    logic [3:0] PC;
    logic [4:0] WordCount;

    instr_feeder #(.DEPTH(16), .TIMEOUT(15)) dut (
        .Clock(Clock), .Reset(Reset), .LoadData(LoadData),
        .LoadWe(LoadWe), .Start(Start), .Done(Done),
        .DIN(DIN), .Run(Run), .Busy(Busy), .Halted(Halted),
        .Fault(Fault), .LoadOvf(LoadOvf), .PC(PC),
        .WordCount(WordCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit       we;
        bit [8:0] d;
        bit       st;
        bit       dn;
        bit       run;
        bit [8:0] din;
        bit       busy;
        bit       halt;
        bit       flt;
        bit [3:0] pc;
        bit [4:0] wc;
    } vec_t;

    vec_t vt[15];
    int n_total = 0;
    int n_pass = 0;
    int nruns;
    logic [8:0] rdin [32];

    function automatic vec_t mk(int we, int d, int st, int dn, int run,
                                int din, int busy, int halt, int flt,
                                int pc, int wc);
        vec_t v;
        v.we = we[0]; v.d = d[8:0]; v.st = st[0]; v.dn = dn[0];
        v.run = run[0]; v.din = din[8:0]; v.busy = busy[0];
        v.halt = halt[0]; v.flt = flt[0]; v.pc = pc[3:0]; v.wc = wc[4:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic load(input int w);
        LoadWe = 1'b1;
        LoadData = w[8:0];
        cyc();
        LoadWe = 1'b0;
    endtask

    // Processor model: Done rises d cycles after the Run cycle.
    task automatic run_prog(input int d);
        int dly;
        bit stop;
        nruns = 0;
        dly = 0;
        stop = 1'b0;
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        for (int i = 0; i < 200 && !stop; i++) begin
            if (Run) begin
                if (nruns < 32) rdin[nruns] = DIN;
                nruns++;
                dly = d;
                Done = 1'b0;
            end else begin
                Done = (dly == 1);
                if (dly > 0) dly--;
            end
            if (Halted || Fault) stop = 1'b1;
            else cyc();
        end
        Done = 1'b0;
        chk("run_bound", int'(stop), 1);
    endtask

    initial begin
        int n;
        vt[0]  = mk(1, 'h040, 0, 0, 0, 'h000, 0, 0, 0, 0, 1);
        vt[1]  = mk(1, 'h005, 0, 0, 0, 'h000, 0, 0, 0, 0, 2);
        vt[2]  = mk(1, 'h008, 0, 0, 0, 'h000, 0, 0, 0, 0, 3);
        vt[3]  = mk(1, 'h081, 0, 0, 0, 'h000, 0, 0, 0, 0, 4);
        vt[4]  = mk(0, 'h000, 1, 0, 1, 'h040, 1, 0, 0, 0, 4);
        vt[5]  = mk(0, 'h000, 0, 0, 0, 'h005, 1, 0, 0, 0, 4);
        vt[6]  = mk(0, 'h000, 0, 1, 1, 'h008, 1, 0, 0, 2, 4);
        vt[7]  = mk(0, 'h000, 0, 0, 0, 'h000, 1, 0, 0, 2, 4);
        vt[8]  = mk(0, 'h000, 0, 1, 1, 'h081, 1, 0, 0, 3, 4);
        vt[9]  = mk(0, 'h000, 0, 0, 0, 'h000, 1, 0, 0, 3, 4);
        vt[10] = mk(0, 'h000, 0, 1, 0, 'h000, 0, 1, 0, 4, 4);
        vt[11] = mk(0, 'h000, 0, 1, 0, 'h000, 0, 1, 0, 4, 4);
        vt[12] = mk(1, 'h1C0, 1, 0, 1, 'h040, 1, 0, 0, 0, 5);
        vt[13] = mk(0, 'h000, 0, 0, 0, 'h005, 1, 0, 0, 0, 5);
        vt[14] = mk(1, 'h1C1, 0, 0, 0, 'h000, 1, 0, 0, 0, 5);

        cyc();
        cyc();
        Reset = 1'b0;
        chk("rst_run", Run, 0);
        chk("rst_din", DIN, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_flags", {Halted, Fault, LoadOvf}, 0);
        chk("rst_pc", PC, 0);
        chk("rst_wc", WordCount, 0);

        for (int i = 0; i < 15; i++) begin
            LoadWe = vt[i].we;
            LoadData = vt[i].d;
            Start = vt[i].st;
            Done = vt[i].dn;
            cyc();
            chk($sformatf("v%0d_run", i), Run, vt[i].run);
            chk($sformatf("v%0d_din", i), DIN, vt[i].din);
            chk($sformatf("v%0d_busy", i), Busy, vt[i].busy);
            chk($sformatf("v%0d_halt", i), Halted, vt[i].halt);
            chk($sformatf("v%0d_flt", i), Fault, vt[i].flt);
            chk($sformatf("v%0d_pc", i), PC, vt[i].pc);
            chk($sformatf("v%0d_wc", i), WordCount, vt[i].wc);
        end
        LoadWe = 1'b0;
        Start = 1'b0;
        Done = 1'b0;

        // Done delayed three cycles past OPERAND
        do_reset();
        load('h040); load('h005); load('h008); load('h081);
        run_prog(4);
        chk("slow_runs", nruns, 3);
        chk("slow_din0", rdin[0], 'h040);
        chk("slow_din1", rdin[1], 'h008);
        chk("slow_din2", rdin[2], 'h081);
        chk("slow_halt", Halted, 1);
        chk("slow_fault", Fault, 0);
        chk("slow_pc", PC, 4);

        // Watchdog timeout; load while busy must be ignored
        do_reset();
        load('h008);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        cyc();
        chk("to_operand", {Busy, Run}, 2'b10);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            LoadWe = (n == 5);
            LoadData = 9'h1FF;
            cyc();
            n++;
            if (Fault) break;
        end
        LoadWe = 1'b0;
        chk("to_cycles", n, 15);
        chk("to_fault", Fault, 1);
        chk("to_pc", PC, 0);
        chk("to_busy", Busy, 0);
        chk("to_wc", WordCount, 1);

        // mvi as the last word faults without a Run pulse
        do_reset();
        load('h008); load('h040);
        run_prog(1);
        chk("trunc_runs", nruns, 1);
        chk("trunc_fault", Fault, 1);
        chk("trunc_halt", Halted, 0);
        chk("trunc_pc", PC, 1);

        // Overflow on the 17th word; word 15 must survive
        do_reset();
        for (int i = 0; i < 16; i++) load('h100 + i);
        chk("ovf_wc16", WordCount, 16);
        chk("ovf_pre", LoadOvf, 0);
        load('h040);
        chk("ovf_wc", WordCount, 16);
        chk("ovf_flag", LoadOvf, 1);
        run_prog(1);
        chk("ovf_runs", nruns, 16);
        chk("ovf_last", rdin[15], 'h10F);
        chk("ovf_halt", Halted, 1);

        // Reset during WAIT_DONE
        do_reset();
        load('h008);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        cyc();
        cyc();
        chk("mid_busy", Busy, 1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        chk("mid_run", Run, 0);
        chk("mid_busy0", Busy, 0);
        chk("mid_pc", PC, 0);
        chk("mid_wc", WordCount, 0);
        Start = 1'b1;
        cyc();
        Start = 1'b0;
        chk("mid_halt", Halted, 1);
        chk("mid_run2", Run, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
